hmac_tag_strip: RTL and testbench
=================================

Name: hmac_tag_strip

Overview:
- Sits directly downstream of the verification stage, between the verify output stream and the host_0 source stream.
- Verification forwards every payload beat and then appends one status/tag beat as the tlast beat of each packet. This block removes that final beat and moves tlast onto the preceding payload beat.
- Records pass/fail per packet and presents a clean payload-only stream to the host.
- A bypass input lets loopback modes that carry no tag beat pass through untouched.

Parameters:
- DATA_BITS, 512, tdata width in bits; tkeep width is DATA_BITS/8.
- ID_BITS, 6, tid width.
- CNT_BITS, 32, width of the statistics counters.

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous reset, active-high
- bypass  in  1  1 = pass packets through unmodified; sampled only at packet boundaries
- s_axis_tvalid / s_axis_tready  in / out  1 / 1  input handshake (from verification)
- s_axis_tdata / s_axis_tkeep / s_axis_tid / s_axis_tlast  in  DATA_BITS / DATA_BITS/8 / ID_BITS / 1  input beat
- m_axis_tvalid / m_axis_tready  out / in  1 / 1  output handshake (to host)
- m_axis_tdata / m_axis_tkeep / m_axis_tid / m_axis_tlast  out  DATA_BITS / DATA_BITS/8 / ID_BITS / 1  output beat
- stats_clr  in  1  one-cycle pulse that clears the counters
- pkt_ok_cnt  out  CNT_BITS  packets whose tag beat has tdata[0]=1
- pkt_fail_cnt  out  CNT_BITS  packets whose tag beat has tdata[0]=0
- tag_valid  out  1  one-cycle pulse when a tag beat is consumed
- tag_ok  out  1  tdata[0] of that tag beat; valid while tag_valid=1
- proto_err  out  1  sticky; set when the tag beat tid differs from the held beat tid

Behaviour:
- Handshake: a beat transfers on tvalid & tready. One held beat gives one-beat lookahead. The paths s_axis_tvalid -> m_axis_tvalid and m_axis_tready -> s_axis_tready are combinational; the data path is registered.
- States:
  - IDLE: hold empty, at a packet boundary.
  - HOLD: one payload beat registered.
  - BYP: a bypass packet is in flight.
- Reset: state=IDLE, hold empty, m_axis_tvalid=0, tag_valid=0, tag_ok=0, proto_err=0, counters=0. m_axis_tdata, tkeep and tid reset to 0.
- The mode decision occurs in IDLE only: on each input beat, bypass=1 routes the packet to BYP and bypass=0 routes it to strip handling. A bypass change mid-packet has no effect until the next IDLE.
- IDLE, bypass=1: pure wire, m_axis_* = s_axis_* and s_axis_tready = m_axis_tready.
  - Accepted beat with tlast=0 -> BYP.
  - Accepted beat with tlast=1 -> stays IDLE.
- BYP: same wire passthrough; an accepted beat with tlast=1 -> IDLE. No counter updates.
- IDLE, bypass=0:
  - s_axis_tready=1 and m_axis_tvalid=0.
  - Beat with tlast=0 loads hold -> HOLD.
  - Beat with tlast=1 is a single-beat packet: it is consumed as a tag, nothing is emitted, tag_valid pulses, a counter increments, and the state stays IDLE.
- HOLD:
  - m_axis_tvalid = s_axis_tvalid. m_axis_tdata, tkeep and tid come from the hold register. m_axis_tlast = s_axis_tlast. s_axis_tready = m_axis_tready.
  - On transfer with s_axis_tlast=0: hold is replaced by the new beat; stay in HOLD.
  - On transfer with s_axis_tlast=1: the tag beat is consumed, tag_valid=1 next cycle, tag_ok=tdata[0], the counter increments, and the state returns to IDLE. If s_axis_tid != hold tid, proto_err is set; the packet is still emitted.
- Tag beat tkeep and tdata[DATA_BITS-1:1] are ignored.
- Latency: a payload beat is emitted in the same cycle its successor beat is presented. A held beat never leaves without a successor.
- Counters wrap modulo 2^CNT_BITS.
  - If stats_clr and an increment coincide, the result is 0 (clear wins).
  - stats_clr also clears proto_err.
- Back-pressure: with m_axis_tready=0 in HOLD, no input is accepted and the hold register is stable.
- A reset mid-packet discards the held beat, returns to IDLE, and leaves no partial output.

Optional Feature:
- Macro: HMAC_TAG_STRIP_STATS_EN.
- Defined: pkt_ok_cnt, pkt_fail_cnt and proto_err are implemented as described above.
- Undefined: the counters and proto_err are tied to 0 and no counter registers are built. tag_valid and tag_ok remain functional.

Test Plan:
- 4-beat packet (3 payload D0..D2, tid=3, plus tag tdata[0]=1), bypass=0, m_axis_tready=1 -> output D0,D1,D2 with tlast only on D2; pkt_ok_cnt=1; tag_valid pulses once with tag_ok=1.
- Single-beat packet (tag only, tdata[0]=0) -> no output beat; pkt_fail_cnt=1; state stays IDLE.
- 3-beat packet with m_axis_tready toggling 1,0,0,1,... -> no beat lost or duplicated; hold is stable while m_axis_tready=0; output is 2 beats with tlast on beat 2.
- bypass=1 on a 3-beat packet -> 3 beats emitted unchanged with the original tlast; counters unchanged. bypass raised mid-packet in strip mode -> the current packet is still stripped.
- Tag beat tid=5 after payload tid=3 -> proto_err=1 (sticky); packet emitted; stats_clr -> proto_err=0 and both counters=0.
- areset asserted while in HOLD -> m_axis_tvalid=0 next cycle and state IDLE; a following 2-beat packet yields 1 output beat with tlast=1.

Source files
------------

// File: rtl/hmac_tag_strip.sv
// Removes the trailing status/tag beat appended by the verification stage and moves tlast onto the last payload beat.
// Optional statistics (pkt_ok_cnt, pkt_fail_cnt, proto_err) are built only when HMAC_TAG_STRIP_STATS_EN is defined.
module hmac_tag_strip #(
  parameter int DATA_BITS = 512,
  parameter int ID_BITS   = 6,
  parameter int CNT_BITS  = 32
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   bypass,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [DATA_BITS-1:0]   s_axis_tdata,
  input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
  input  logic [ID_BITS-1:0]     s_axis_tid,
  input  logic                   s_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [DATA_BITS-1:0]   m_axis_tdata,
  output logic [DATA_BITS/8-1:0] m_axis_tkeep,
  output logic [ID_BITS-1:0]     m_axis_tid,
  output logic                   m_axis_tlast,
  input  logic                   stats_clr,
  output logic [CNT_BITS-1:0]    pkt_ok_cnt,
  output logic [CNT_BITS-1:0]    pkt_fail_cnt,
  output logic                   tag_valid,
  output logic                   tag_ok,
  output logic                   proto_err
);

  localparam int KEEP_BITS = DATA_BITS / 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_BYP
  } state_t;

  state_t                 state_reg, state_next;
  logic [DATA_BITS-1:0]   hold_data_reg;
  logic [KEEP_BITS-1:0]   hold_keep_reg;
  logic [ID_BITS-1:0]     hold_id_reg;
  logic                   tag_valid_reg;
  logic                   tag_ok_reg;

  logic                   passthru;
  logic                   hold_load;
  logic                   tag_take;

  always_comb begin
    state_next    = state_reg;
    passthru      = 1'b0;
    hold_load     = 1'b0;
    tag_take      = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = hold_data_reg;
    m_axis_tkeep  = hold_keep_reg;
    m_axis_tid    = hold_id_reg;
    m_axis_tlast  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (bypass) begin
          passthru = 1'b1;
          if (s_axis_tvalid && m_axis_tready && !s_axis_tlast) begin
            state_next = ST_BYP;
          end
        end else begin
          // Nothing is emitted until a successor beat proves the first one is payload.
          s_axis_tready = 1'b1;
          if (s_axis_tvalid) begin
            if (s_axis_tlast) begin
              tag_take = 1'b1;
            end else begin
              hold_load  = 1'b1;
              state_next = ST_HOLD;
            end
          end
        end
      end

      ST_HOLD: begin
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tlast  = s_axis_tlast;
        s_axis_tready = m_axis_tready;
        if (s_axis_tvalid && m_axis_tready) begin
          if (s_axis_tlast) begin
            tag_take   = 1'b1;
            state_next = ST_IDLE;
          end else begin
            hold_load = 1'b1;
          end
        end
      end

      ST_BYP: begin
        passthru = 1'b1;
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (passthru) begin
      m_axis_tvalid = s_axis_tvalid;
      s_axis_tready = m_axis_tready;
      m_axis_tdata  = s_axis_tdata;
      m_axis_tkeep  = s_axis_tkeep;
      m_axis_tid    = s_axis_tid;
      m_axis_tlast  = s_axis_tlast;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg     <= ST_IDLE;
      hold_data_reg <= '0;
      hold_keep_reg <= '0;
      hold_id_reg   <= '0;
      tag_valid_reg <= 1'b0;
      tag_ok_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tag_valid_reg <= tag_take;
      if (hold_load) begin
        hold_data_reg <= s_axis_tdata;
        hold_keep_reg <= s_axis_tkeep;
        hold_id_reg   <= s_axis_tid;
      end
      if (tag_take) begin
        tag_ok_reg <= s_axis_tdata[0];
      end
    end
  end

  assign tag_valid = tag_valid_reg;
  assign tag_ok    = tag_ok_reg;

`ifdef HMAC_TAG_STRIP_STATS_EN
  logic id_mismatch;
  logic proto_err_reg;

  // A tag taken straight from IDLE has no held beat to compare against.
  assign id_mismatch = tag_take && (state_reg == ST_HOLD) && (s_axis_tid != hold_id_reg);

  always_ff @(posedge aclk) begin
    if (areset || stats_clr) begin
      proto_err_reg <= 1'b0;
    end else if (id_mismatch) begin
      proto_err_reg <= 1'b1;
    end
  end

  // Index 0 counts passing tags, index 1 failing tags.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    localparam logic OK_SEL = (gi == 0) ? 1'b1 : 1'b0;
    logic [CNT_BITS-1:0] cnt_reg;

    always_ff @(posedge aclk) begin
      if (areset || stats_clr) begin
        cnt_reg <= '0;
      end else if (tag_take && (s_axis_tdata[0] == OK_SEL)) begin
        cnt_reg <= cnt_reg + CNT_BITS'(1);
      end
    end
  end

  assign pkt_ok_cnt   = g_cnt[0].cnt_reg;
  assign pkt_fail_cnt = g_cnt[1].cnt_reg;
  assign proto_err    = proto_err_reg;
`else
  logic stats_clr_unused;

  assign stats_clr_unused = stats_clr;
  assign pkt_ok_cnt       = '0;
  assign pkt_fail_cnt     = '0;
  assign proto_err        = 1'b0;
`endif

endmodule

// File: tb/tb_hmac_tag_strip.sv
// Directed bench for hmac_tag_strip: expected output beats and tag pulses are queued at drive time and checked by a monitor.
// Statistics expectations follow HMAC_TAG_STRIP_STATS_EN (zero when the feature is not built).
module tb_hmac_tag_strip;

  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int IW = 6;
  localparam int CW = 32;

`ifdef HMAC_TAG_STRIP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [IW-1:0] id;
    logic          last;
  } beat_t;

  logic          aclk = 1'b0;
  logic          areset;
  logic          bypass;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic [IW-1:0] s_axis_tid;
  logic          s_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [IW-1:0] m_axis_tid;
  logic          m_axis_tlast;
  logic          stats_clr;
  logic [CW-1:0] pkt_ok_cnt;
  logic [CW-1:0] pkt_fail_cnt;
  logic          tag_valid;
  logic          tag_ok;
  logic          proto_err;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  bit    tag_q[$];
  int    ok_m = 0;
  int    fail_m = 0;
  bit    perr_m = 1'b0;
  bit    toggle_mode = 1'b0;
  logic [3:0] rdy_pat = 4'b1001;
  int    pidx = 0;

  hmac_tag_strip #(.DATA_BITS(DW), .ID_BITS(IW), .CNT_BITS(CW)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .bypass        (bypass),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tid    (s_axis_tid),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tid    (m_axis_tid),
    .m_axis_tlast  (m_axis_tlast),
    .stats_clr     (stats_clr),
    .pkt_ok_cnt    (pkt_ok_cnt),
    .pkt_fail_cnt  (pkt_fail_cnt),
    .tag_valid     (tag_valid),
    .tag_ok        (tag_ok),
    .proto_err     (proto_err)
  );

  always #5 aclk = ~aclk;

  // Sink ready pattern 1,0,0,1 while toggle_mode is set.
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      if (toggle_mode) begin
        m_axis_tready = rdy_pat[pidx % 4];
        pidx++;
      end
    end
  end

  // Output monitor, sampled mid-cycle.
  always @(negedge aclk) begin
    if (!areset) begin
      if (m_axis_tvalid && m_axis_tready) begin
        beat_t got;
        beat_t exp;
        got = {m_axis_tdata, m_axis_tkeep, m_axis_tid, m_axis_tlast};
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL out_unexpected got=%h exp=<none>", got);
        end
        if (exp_q.size() != 0) begin
          exp = exp_q.pop_front();
          checks++;
          assert (got === exp) else begin
            errors++;
            $error("FAIL out_beat got=%h exp=%h", got, exp);
          end
          $display("out beat data=%h keep=%h tid=%0d last=%0b", got.d, got.k, got.id, got.last);
        end
      end else if (m_axis_tvalid && exp_q.size() != 0) begin
        checks++;
        assert (m_axis_tdata === exp_q[0].d) else begin
          errors++;
          $error("FAIL stall_stable got=%h exp=%h", m_axis_tdata, exp_q[0].d);
        end
      end
      if (tag_valid) begin
        checks++;
        assert (tag_q.size() != 0) else begin
          errors++;
          $error("FAIL tag_unexpected got=%0b exp=<none>", tag_ok);
        end
        if (tag_q.size() != 0) begin
          bit et;
          et = tag_q.pop_front();
          checks++;
          assert (tag_ok === et) else begin
            errors++;
            $error("FAIL tag_ok got=%0b exp=%0b", tag_ok, et);
          end
          $display("tag pulse ok=%0b", tag_ok);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat transferred.
  task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k,
                      input logic [IW-1:0] id, input logic last);
    int waited;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tid    = id;
    s_axis_tlast  = last;
    waited = 0;
    @(negedge aclk);
    while (!s_axis_tready && waited < 50) begin
      @(negedge aclk);
      waited++;
    end
    checks++;
    assert (s_axis_tready === 1'b1) else begin
      errors++;
      $error("FAIL send_timeout got=%0b exp=1", s_axis_tready);
    end
    $display("in  beat data=%h tid=%0d last=%0b", d, id, last);
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic push_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                           input logic [IW-1:0] id, input logic last);
    beat_t b;
    b.d = d;
    b.k = k;
    b.id = id;
    b.last = last;
    exp_q.push_back(b);
  endtask

  task automatic check_stats(input string tag);
    logic [CW-1:0] e_ok;
    logic [CW-1:0] e_fail;
    logic          e_perr;
    e_ok   = STATS ? CW'(ok_m) : '0;
    e_fail = STATS ? CW'(fail_m) : '0;
    e_perr = STATS ? perr_m : 1'b0;
    @(negedge aclk);
    checks++;
    assert (pkt_ok_cnt === e_ok) else begin
      errors++;
      $error("FAIL %s ok_cnt got=%0d exp=%0d", tag, pkt_ok_cnt, e_ok);
    end
    checks++;
    assert (pkt_fail_cnt === e_fail) else begin
      errors++;
      $error("FAIL %s fail_cnt got=%0d exp=%0d", tag, pkt_fail_cnt, e_fail);
    end
    checks++;
    assert (proto_err === e_perr) else begin
      errors++;
      $error("FAIL %s proto_err got=%0b exp=%0b", tag, proto_err, e_perr);
    end
    $display("stats %s ok=%0d fail=%0d perr=%0b", tag, pkt_ok_cnt, pkt_fail_cnt, proto_err);
    @(posedge aclk);
    #1;
  endtask

  initial begin
    areset        = 1'b1;
    bypass        = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tid    = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    stats_clr     = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;

    // Reset state
    @(negedge aclk);
    checks++;
    assert (m_axis_tvalid === 1'b0) else begin
      errors++; $error("FAIL rst_tvalid got=%0b exp=0", m_axis_tvalid);
    end
    checks++;
    assert (m_axis_tdata === '0) else begin
      errors++; $error("FAIL rst_tdata got=%h exp=0", m_axis_tdata);
    end
    checks++;
    assert (tag_valid === 1'b0 && tag_ok === 1'b0) else begin
      errors++; $error("FAIL rst_tag got=%0b%0b exp=00", tag_valid, tag_ok);
    end
    @(posedge aclk);
    #1;
    check_stats("reset");

    // 4-beat packet, tag passes
    push_beat(64'hD0D0_0000_0000_0001, 8'hFF, 6'd3, 1'b0);
    push_beat(64'hD1D1_0000_0000_0002, 8'hFF, 6'd3, 1'b0);
    push_beat(64'hD2D2_0000_0000_0003, 8'h0F, 6'd3, 1'b1);
    tag_q.push_back(1'b1);
    send(64'hD0D0_0000_0000_0001, 8'hFF, 6'd3, 1'b0);
    send(64'hD1D1_0000_0000_0002, 8'hFF, 6'd3, 1'b0);
    send(64'hD2D2_0000_0000_0003, 8'h0F, 6'd3, 1'b0);
    send(64'hA5A5_A5A5_A5A5_A5A5, 8'h01, 6'd3, 1'b1);
    ok_m++;
    idle(2);
    check_stats("pkt4");

    // Single-beat packet, tag fails, nothing emitted
    tag_q.push_back(1'b0);
    send(64'hFFFF_0000_FFFF_FFFE, 8'hFF, 6'd1, 1'b1);
    fail_m++;
    idle(2);
    check_stats("single");

    // Back-pressure with sink ready toggling 1,0,0,1
    push_beat(64'h1111_2222_3333_4444, 8'hFF, 6'd7, 1'b0);
    push_beat(64'h5555_6666_7777_8888, 8'h3F, 6'd7, 1'b1);
    tag_q.push_back(1'b1);
    toggle_mode = 1'b1;
    send(64'h1111_2222_3333_4444, 8'hFF, 6'd7, 1'b0);
    send(64'h5555_6666_7777_8888, 8'h3F, 6'd7, 1'b0);
    send(64'h0000_0000_0000_0001, 8'hFF, 6'd7, 1'b1);
    ok_m++;
    toggle_mode = 1'b0;
    m_axis_tready = 1'b1;
    idle(2);
    check_stats("bp");

    // Bypass packet passes through unchanged
    bypass = 1'b1;
    push_beat(64'hB0B0_B0B0_0000_0000, 8'hFF, 6'd2, 1'b0);
    push_beat(64'hB1B1_B1B1_0000_0000, 8'hF0, 6'd2, 1'b0);
    push_beat(64'hB2B2_B2B2_0000_0001, 8'h03, 6'd2, 1'b1);
    send(64'hB0B0_B0B0_0000_0000, 8'hFF, 6'd2, 1'b0);
    send(64'hB1B1_B1B1_0000_0000, 8'hF0, 6'd2, 1'b0);
    send(64'hB2B2_B2B2_0000_0001, 8'h03, 6'd2, 1'b1);
    idle(2);
    check_stats("bypass");

    // Bypass raised mid-packet in strip mode
    bypass = 1'b0;
    push_beat(64'hC0C0_0000_0000_0000, 8'hFF, 6'd9, 1'b0);
    push_beat(64'hC1C1_0000_0000_0000, 8'hFF, 6'd9, 1'b1);
    tag_q.push_back(1'b1);
    send(64'hC0C0_0000_0000_0000, 8'hFF, 6'd9, 1'b0);
    bypass = 1'b1;
    send(64'hC1C1_0000_0000_0000, 8'hFF, 6'd9, 1'b0);
    send(64'h0000_0000_0000_0003, 8'hFF, 6'd9, 1'b1);
    ok_m++;
    bypass = 1'b0;
    idle(2);
    check_stats("midbyp");

    // Tag tid differs from payload tid
    push_beat(64'hE0E0_E0E0_E0E0_E0E0, 8'hFF, 6'd3, 1'b1);
    tag_q.push_back(1'b1);
    send(64'hE0E0_E0E0_E0E0_E0E0, 8'hFF, 6'd3, 1'b0);
    send(64'h0000_0000_0000_0001, 8'hFF, 6'd5, 1'b1);
    ok_m++;
    perr_m = 1'b1;
    idle(2);
    check_stats("proto");

    stats_clr = 1'b1;
    idle(1);
    stats_clr = 1'b0;
    ok_m = 0;
    fail_m = 0;
    perr_m = 1'b0;
    idle(1);
    check_stats("clr");

    // Clear coinciding with an increment leaves zero
    tag_q.push_back(1'b1);
    stats_clr = 1'b1;
    send(64'h0000_0000_0000_0001, 8'hFF, 6'd0, 1'b1);
    stats_clr = 1'b0;
    idle(2);
    check_stats("clr_wins");

    // Reset while a beat is held
    send(64'h4444_4444_4444_4444, 8'hFF, 6'd4, 1'b0);
    areset = 1'b1;
    idle(1);
    areset = 1'b0;
    ok_m = 0;
    fail_m = 0;
    perr_m = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 64'h7777_0000_0000_7777;
    s_axis_tkeep  = 8'hFF;
    s_axis_tid    = 6'd4;
    s_axis_tlast  = 1'b0;
    @(negedge aclk);
    checks++;
    assert (m_axis_tvalid === 1'b0) else begin
      errors++; $error("FAIL rst_hold_tvalid got=%0b exp=0", m_axis_tvalid);
    end
    s_axis_tvalid = 1'b0;
    @(posedge aclk);
    #1;
    push_beat(64'h7777_0000_0000_7777, 8'hFF, 6'd4, 1'b1);
    tag_q.push_back(1'b0);
    send(64'h7777_0000_0000_7777, 8'hFF, 6'd4, 1'b0);
    send(64'h0000_0000_0000_0000, 8'hFF, 6'd4, 1'b1);
    fail_m++;
    idle(2);
    check_stats("after_rst");

    idle(3);
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++; $error("FAIL out_pending got=%0d exp=0", exp_q.size());
    end
    checks++;
    assert (tag_q.size() == 0) else begin
      errors++; $error("FAIL tag_pending got=%0d exp=0", tag_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
